// File: rtl/bram_write_scheduler_pkg.sv
// Shared definitions for the BRAM write scheduler and its round-robin arbiter.
package bram_write_scheduler_pkg;

  // Scheduler operating mode: normal arbitration or the zero-fill sweep.
  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } sched_state_t;

  // Number of write requesters sharing the BRAM port.
  localparam int NUM_REQ = 2;

  // Byte-enable width for a given data width (data width is a multiple of 8).
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/bram_rr_arbiter.sv
// Two-requester round-robin arbiter. The grant is combinational from the
// requests and the pointer; the pointer moves to the other requester whenever
// the caller signals that the granted request was consumed.
module bram_rr_arbiter (
  input  logic aclk,
  input  logic areset,
  input  logic enable,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic gnt0,
  output logic gnt1,
  output logic rr_ptr
);

  // Grant selection: a lone requester always wins, contention follows the pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (enable) begin
      gnt0 = req0 && (!req1 || !rr_ptr);
      gnt1 = req1 && (!req0 ||  rr_ptr);
    end
  end

  // Pointer register: after a transfer the other requester is preferred next.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state is always written with <= so every register samples pre-edge values.
    if (areset) begin
      rr_ptr <= 1'b0;
    end else if (advance) begin
      rr_ptr <= gnt0;
    end
  end

endmodule

// File: rtl/bram_write_scheduler.sv
// Shares BRAM port A between two write requesters (round-robin) and provides a
// zero-fill engine that sweeps every word address once on command. All BRAM
// port signals are registered, one write per cycle at most.
module bram_write_scheduler
  import bram_write_scheduler_pkg::*;
#(
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH = 10
) (
  input  logic                                   aclk,
  input  logic                                   areset,

  input  logic                                   clear_start,
  output logic                                   clear_busy,

  input  logic [BRAM_ADDR_WIDTH-1:0]             s0_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]             s0_data,
  input  logic [strb_width(BRAM_DATA_WIDTH)-1:0] s0_strb,
  input  logic                                   s0_valid,
  output logic                                   s0_ready,

  input  logic [BRAM_ADDR_WIDTH-1:0]             s1_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]             s1_data,
  input  logic [strb_width(BRAM_DATA_WIDTH)-1:0] s1_strb,
  input  logic                                   s1_valid,
  output logic                                   s1_ready,

  output logic                                   bram_porta_clk,
  output logic                                   bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]             bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]             bram_porta_wrdata,
  output logic [strb_width(BRAM_DATA_WIDTH)-1:0] bram_porta_we
);

  localparam int STRB_W = strb_width(BRAM_DATA_WIDTH);

  // Clear counter carries one extra bit; its MSB flags that the last address was issued.
  localparam logic [BRAM_ADDR_WIDTH:0] CLR_ONE = {{BRAM_ADDR_WIDTH{1'b0}}, 1'b1};

  sched_state_t               state;
  logic [BRAM_ADDR_WIDTH:0]   clr_addr;
  logic [BRAM_ADDR_WIDTH:0]   clr_next;

  logic arb_enable;
  logic gnt0;
  logic gnt1;
  logic xfer0;
  logic xfer1;
  logic xfer;
  logic rr_ptr;

  assign bram_porta_clk = aclk;
  assign bram_porta_rst = areset;

  // Requesters are only served in ARB and never while reset is held.
  assign arb_enable = (state == ST_ARB) && !areset;

  bram_rr_arbiter u_arbiter (
    .aclk    (aclk),
    .areset  (areset),
    .enable  (arb_enable),
    .req0    (s0_valid),
    .req1    (s1_valid),
    .advance (xfer),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rr_ptr  (rr_ptr)
  );

  assign s0_ready = gnt0;
  assign s1_ready = gnt1;

  // A grant already implies the matching valid; the AND keeps the handshake explicit.
  assign xfer0 = s0_valid && s0_ready;
  assign xfer1 = s1_valid && s1_ready;
  assign xfer  = xfer0 || xfer1;

  assign clr_next   = clr_addr + CLR_ONE;
  assign clear_busy = (state == ST_CLEAR);

  // Mode FSM plus the registered BRAM port: accepted requests land one cycle
  // later, the sweep writes zeros with all byte lanes enabled.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state             <= ST_ARB;
      clr_addr          <= '0;
      bram_porta_addr   <= '0;
      bram_porta_wrdata <= '0;
      bram_porta_we     <= '0;
    end else begin
      unique case (state)
        ST_ARB: begin
          if (xfer0) begin
            bram_porta_addr   <= s0_addr;
            bram_porta_wrdata <= s0_data;
            bram_porta_we     <= s0_strb;
          end else if (xfer1) begin
            bram_porta_addr   <= s1_addr;
            bram_porta_wrdata <= s1_data;
            bram_porta_we     <= s1_strb;
          end else begin
            // Idle cycle: address and data hold, only the enables drop.
            bram_porta_we <= '0;
          end
          // A request granted alongside clear_start is written before the sweep.
          if (clear_start) begin
            state <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          bram_porta_addr   <= clr_addr[BRAM_ADDR_WIDTH-1:0];
          bram_porta_wrdata <= '0;
          bram_porta_we     <= {STRB_W{1'b1}};
          if (clr_next[BRAM_ADDR_WIDTH]) begin
            clr_addr <= '0;
            state    <= ST_ARB;
          end else begin
            clr_addr <= clr_next;
          end
        end

        default: begin
          state <= ST_ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_write_scheduler.sv
// Directed bench for bram_write_scheduler with a small reference model that
// predicts readys, clear_busy and the next-cycle BRAM port contents.
module tb_bram_write_scheduler;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          aclk = 1'b0;
  logic          areset;
  logic          clear_start;
  logic          clear_busy;
  logic [AW-1:0] s0_addr;
  logic [DW-1:0] s0_data;
  logic [SW-1:0] s0_strb;
  logic          s0_valid;
  logic          s0_ready;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;
  logic [SW-1:0] s1_strb;
  logic          s1_valid;
  logic          s1_ready;
  logic          bram_porta_clk;
  logic          bram_porta_rst;
  logic [AW-1:0] bram_porta_addr;
  logic [DW-1:0] bram_porta_wrdata;
  logic [SW-1:0] bram_porta_we;

  always #5 aclk = ~aclk;

  bram_write_scheduler #(
    .BRAM_DATA_WIDTH (DW),
    .BRAM_ADDR_WIDTH (AW)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .clear_start       (clear_start),
    .clear_busy        (clear_busy),
    .s0_addr           (s0_addr),
    .s0_data           (s0_data),
    .s0_strb           (s0_strb),
    .s0_valid          (s0_valid),
    .s0_ready          (s0_ready),
    .s1_addr           (s1_addr),
    .s1_data           (s1_data),
    .s1_strb           (s1_strb),
    .s1_valid          (s1_valid),
    .s1_ready          (s1_ready),
    .bram_porta_clk    (bram_porta_clk),
    .bram_porta_rst    (bram_porta_rst),
    .bram_porta_addr   (bram_porta_addr),
    .bram_porta_wrdata (bram_porta_wrdata),
    .bram_porta_we     (bram_porta_we)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] we;
  } wr_t;

  wr_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  logic          m_clear;
  logic          m_rr;
  int            m_clr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  logic [1:0]    last_rdy;
  int            busy_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_clear = 1'b0;
    m_rr    = 1'b0;
    m_clr   = 0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  // One clock cycle: drive at the falling edge, check readys, predict the port,
  // then check the registered port just after the rising edge.
  task automatic cyc(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic [SW-1:0] st0, input logic v1, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d1, input logic [SW-1:0] st1, input logic cs);
    logic g0;
    logic g1;
    wr_t  e;
    wr_t  got;
    s0_valid = v0; s0_addr = a0; s0_data = d0; s0_strb = st0;
    s1_valid = v1; s1_addr = a1; s1_data = d1; s1_strb = st1;
    clear_start = cs;
    #1;
    g0 = !m_clear && v0 && (!v1 || !m_rr);
    g1 = !m_clear && v1 && (!v0 ||  m_rr);
    last_rdy = {s1_ready, s0_ready};
    if (clear_busy === 1'b1) busy_seen++;
    check("s0_ready", 64'(s0_ready), 64'(g0));
    check("s1_ready", 64'(s1_ready), 64'(g1));
    check("clear_busy", 64'(clear_busy), 64'(m_clear));
    if (m_clear) begin
      e = '{addr: AW'(m_clr), data: '0, we: {SW{1'b1}}};
      m_clr++;
      if (m_clr == DEPTH) begin
        m_clr   = 0;
        m_clear = 1'b0;
      end
    end else begin
      if (g0) begin
        e    = '{addr: a0, data: d0, we: st0};
        m_rr = 1'b1;
      end else if (g1) begin
        e    = '{addr: a1, data: d1, we: st1};
        m_rr = 1'b0;
      end else begin
        e = '{addr: m_addr, data: m_data, we: '0};
      end
      if (cs) m_clear = 1'b1;
    end
    m_addr = e.addr;
    m_data = e.data;
    exp_q.push_back(e);
    @(posedge aclk);
    #1;
    got = '{addr: bram_porta_addr, data: bram_porta_wrdata, we: bram_porta_we};
    e = exp_q.pop_front();
    check("port_addr", 64'(got.addr), 64'(e.addr));
    check("port_data", 64'(got.data), 64'(e.data));
    check("port_we",   64'(got.we),   64'(e.we));
    @(negedge aclk);
  endtask

  task automatic idle(input logic cs);
    cyc(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, cs);
  endtask

  // Holds reset for one edge with both requesters asking; readys must stay low.
  task automatic do_reset();
    areset   = 1'b1;
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    clear_start = 1'b0;
    #1;
    check("rst_s0_ready", 64'(s0_ready), 64'(0));
    check("rst_s1_ready", 64'(s1_ready), 64'(0));
    @(posedge aclk);
    #1;
    check("rst_clear_busy", 64'(clear_busy), 64'(0));
    check("rst_we",         64'(bram_porta_we), 64'(0));
    check("rst_addr",       64'(bram_porta_addr), 64'(0));
    check("rst_data",       64'(bram_porta_wrdata), 64'(0));
    check("rst_s0_ready_h", 64'(s0_ready), 64'(0));
    check("rst_s1_ready_h", 64'(s1_ready), 64'(0));
    @(negedge aclk);
    areset   = 1'b0;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    model_reset();
  endtask

  initial begin
    areset = 1'b1;
    clear_start = 1'b0;
    s0_valid = 1'b0; s0_addr = '0; s0_data = '0; s0_strb = '0;
    s1_valid = 1'b0; s1_addr = '0; s1_data = '0; s1_strb = '0;
    busy_seen = 0;
    last_rdy  = '0;
    model_reset();
    @(negedge aclk);
    do_reset();

    // Lone s0 write lands one cycle after acceptance.
    cyc(1'b1, 4'h5, 32'hDEADBEEF, 4'hF, 1'b0, '0, '0, '0, 1'b0);
    check("t1_s0_granted", 64'(last_rdy), 64'(2'b01));
    idle(1'b0);

    // Fresh reset, then continuous contention: s0, s1, s0, s1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, AW'(i), 32'hA000_0000 + i, 4'hF, 1'b1, AW'(8 + i), 32'hB000_0000 + i, 4'hF, 1'b0);
      check("contend_grant", 64'(last_rdy), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
    end
    idle(1'b0);

    // Partial and empty strobes; an empty-strobe transfer still moves the pointer.
    cyc(1'b1, 4'h1, 32'h1111_1111, 4'hF, 1'b0, '0, '0, '0, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'h2, 32'h2222_2222, 4'h3, 1'b0);
    cyc(1'b1, 4'h3, 32'h3333_3333, 4'hF, 1'b0, '0, '0, '0, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'h4, 32'h4444_4444, 4'h0, 1'b0);
    check("strb0_accepted", 64'(last_rdy), 64'(2'b10));
    cyc(1'b1, 4'h6, 32'h6666_6666, 4'hC, 1'b1, 4'h7, 32'h7777_7777, 4'hF, 1'b0);
    check("after_strb0_s0_wins", 64'(last_rdy), 64'(2'b01));
    idle(1'b0);

    // Clear started while s0 is valid: s0 first, then a 16-word sweep, a
    // second clear_start mid-fill is ignored, s0 backlog served on return.
    busy_seen = 0;
    cyc(1'b1, 4'hA, 32'hCAFE_0001, 4'hF, 1'b0, '0, '0, '0, 1'b1);
    check("clr_same_cycle_grant", 64'(last_rdy), 64'(2'b01));
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 4'hB, 32'h0BAD_0000 + i, 4'hF, 1'b0, '0, '0, '0, (i == 4));
    end
    for (int i = 0; i < 20; i++) idle(1'b0);
    check("clear_busy_cycles", 64'(busy_seen), 64'(DEPTH));

    // Reset in the middle of a fill aborts it; clear address restarts at 0.
    idle(1'b1);
    while (m_clr != 7) idle(1'b0);
    do_reset();
    cyc(1'b1, 4'hC, 32'h5A5A_5A5A, 4'hF, 1'b1, 4'hD, 32'hA5A5_A5A5, 4'hF, 1'b0);
    check("post_rst_s0_pref", 64'(last_rdy), 64'(2'b01));
    busy_seen = 0;
    idle(1'b1);
    for (int i = 0; i < DEPTH + 3; i++) idle(1'b0);
    check("refill_busy_cycles", 64'(busy_seen), 64'(DEPTH));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_write_scheduler.md
Name: bram_write_scheduler

Overview:
- Shares one BRAM port A between two write requesters (s0, s1) using round-robin arbitration.
- Contains a built-in clear engine that zero-fills the whole BRAM on command.
- Sits between the AXI-side BRAM writer logic and a stream-side producer (e.g. a sample recorder), which both target the same block RAM.
- The BRAM port is registered; there is at most one write per cycle.

Parameters:
BRAM_DATA_WIDTH, 32, width of the BRAM data word; must be a multiple of 8.
BRAM_ADDR_WIDTH, 10, width of the BRAM word address; the BRAM depth is 2^BRAM_ADDR_WIDTH.

Ports:
aclk  in  1  single clock for all logic and for the BRAM port.
areset  in  1  synchronous, active-high reset.
clear_start  in  1  one-cycle pulse that starts a full zero-fill of the BRAM.
clear_busy  out  1  high while the zero-fill is in progress.
s0_addr  in  BRAM_ADDR_WIDTH  requester 0 word address.
s0_data  in  BRAM_DATA_WIDTH  requester 0 write data.
s0_strb  in  BRAM_DATA_WIDTH/8  requester 0 byte enables.
s0_valid  in  1  requester 0 request valid.
s0_ready  out  1  requester 0 request accepted this cycle.
s1_addr, s1_data, s1_strb, s1_valid, s1_ready  as for s0, for requester 1.
bram_porta_clk  out  1  equals aclk.
bram_porta_rst  out  1  equals areset.
bram_porta_addr  out  BRAM_ADDR_WIDTH  registered write address.
bram_porta_wrdata  out  BRAM_DATA_WIDTH  registered write data.
bram_porta_we  out  BRAM_DATA_WIDTH/8  registered byte write enables.

Behaviour:
- Reset values:
  - state = ARB, rr pointer = 0 (s0 preferred first), clear address = 0.
  - clear_busy = 0, s0_ready = s1_ready = 0 while areset is high.
  - bram_porta_addr = 0, bram_porta_wrdata = 0, bram_porta_we = 0.
- States:
  - ARB: normal arbitration.
  - CLEAR: zero-fill in progress.
- ARB grant rule (combinational from the valids, the rr pointer and the state):
  - Only one valid: grant that requester.
  - Both valid: grant s0 if rr = 0, else s1.
  - sN_ready = (state == ARB) and grant == N.
  - A transfer happens when valid and ready are both high. No requester waits more than one transfer.
- On a transfer by requester N:
  - rr pointer becomes the other requester.
  - The next cycle, the BRAM port carries that request's addr/data, with we = strb.
  - Latency from acceptance to BRAM write is exactly 1 cycle.
  - A request with strb = 0 is still accepted, still updates the rr pointer, and drives we = 0.
- In any cycle with no transfer and not in CLEAR, bram_porta_we is 0 in the following cycle. Addr and data hold their previous values.
- ARB to CLEAR:
  - clear_start high in ARB moves to CLEAR on the next edge.
  - A request granted in the same cycle as clear_start is still accepted and written first.
  - clear_busy is high from the first CLEAR cycle.
- CLEAR behaviour:
  - Each cycle, registers addr = clear address, data = 0, we = all ones, then increments the clear address.
  - Addresses 0 .. 2^BRAM_ADDR_WIDTH-1 are written once each, in order, one per cycle.
  - The fill takes 2^BRAM_ADDR_WIDTH cycles.
- CLEAR to ARB:
  - After the write of the last address is registered, return to ARB and clear the clear address to 0.
  - clear_busy drops in the same cycle ARB resumes; arbitration may grant in that cycle.
- While in CLEAR:
  - Both readys are 0.
  - clear_start is ignored; it is not queued.
  - The rr pointer is unchanged.
- Reset mid-clear: aborts at once; all state returns to its reset values. The BRAM contents are left partially cleared.
- The clear address counter is BRAM_ADDR_WIDTH+1 bits wide; its MSB marks the end of the fill (no wrap ambiguity).

Decomposition:
- Shared package: state enum (ARB, CLEAR), localparam NUM_REQ = 2, helper function for the byte-enable width (BRAM_DATA_WIDTH/8).
- One sub-module: bram_rr_arbiter.
  - Two-request round-robin grant, with the pointer register and an advance input.
  - Reusable for other shared-BRAM blocks.

Test Plan:
- Reset, then s0_valid = 1 only with addr 0x005, data 0xDEADBEEF, strb 0xF -> s0_ready = 1 that cycle; next cycle addr = 0x005, wrdata = 0xDEADBEEF, we = 0xF; s1_ready = 0 throughout.
- s0 and s1 both valid continuously for 4 cycles right after reset -> grants are s0, s1, s0, s1; the BRAM sees both streams' writes interleaved, each 1 cycle after acceptance.
- s1 valid with strb = 0x3 -> we = 0x3 one cycle later; then strb = 0x0 -> accepted, we = 0x0, and the rr pointer still advances (s0 wins the next contention).
- BRAM_ADDR_WIDTH = 4; pulse clear_start while s0 is valid -> s0 write first, then 16 cycles of addr 0..15 with data 0 and we = 0xF; clear_busy is high for exactly 16 cycles; readys are 0 during the fill; the s0 backlog is granted in the first ARB cycle.
- Pulse clear_start again during CLEAR -> ignored; the fill length stays 16 cycles and there is no second fill.
- Assert areset at clear address 7 -> the next cycle has clear_busy = 0, we = 0, both readys 0; after release, s0 is preferred and the clear address restarts at 0 on the next clear_start.
